// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR + R) between
// NUM_MASTERS requesters. One transaction is in flight at a time: the grant
// is taken in IDLE, the address is forwarded in ADDR, and the read beats are
// routed back to the granted master in DATA until RLAST is accepted.
module axi_read_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_SIZE   = 32,
   parameter int DATA_SIZE   = 32,
   parameter int GW          = $clog2(NUM_MASTERS)
) (
   input  logic                           i_aclk,
   input  logic                           i_areset_n,
   // master side
   input  logic [NUM_MASTERS-1:0]         i_m_arvalid,
   output logic [NUM_MASTERS-1:0]         o_m_arready,
   input  logic [NUM_MASTERS*ADDR_SIZE-1:0] i_m_araddr,
   input  logic [NUM_MASTERS*8-1:0]       i_m_arlen,
   output logic [NUM_MASTERS-1:0]         o_m_rvalid,
   input  logic [NUM_MASTERS-1:0]         i_m_rready,
   output logic [DATA_SIZE-1:0]           o_m_rdata,
   output logic [1:0]                     o_m_rresp,
   output logic                           o_m_rlast,
   // slave side
   output logic                           o_s_arvalid,
   input  logic                           i_s_arready,
   output logic [ADDR_SIZE-1:0]           o_s_araddr,
   output logic [7:0]                     o_s_arlen,
   input  logic                           i_s_rvalid,
   output logic                           o_s_rready,
   input  logic [DATA_SIZE-1:0]           i_s_rdata,
   input  logic [1:0]                     i_s_rresp,
   input  logic                           i_s_rlast,
   // status
   output logic [GW-1:0]                  o_grant,
   output logic                           o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] last_grant_nxt;
   logic [GW-1:0] grant_nxt;
   logic [GW-1:0] rr_pick;
   logic          rr_found;

   // Round-robin pick: first requester after the previous winner, with wrap.
   // The modulo keeps the index below NUM_MASTERS for any master count.
   always_comb begin
      rr_pick  = '0;
      rr_found = 1'b0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         if (!rr_found && i_m_arvalid[(int'(last_grant) + i) % NUM_MASTERS]) begin
            rr_found = 1'b1;
            rr_pick  = GW'((int'(last_grant) + i) % NUM_MASTERS);
         end
      end
   end

   // State, grant and round-robin history registers.
   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         state      <= IDLE;
         o_grant    <= '0;
         last_grant <= GW'(NUM_MASTERS - 1);
      end else begin
         state      <= state_nxt;
         o_grant    <= grant_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Next-state logic and handshake steering toward the granted master.
   always_comb begin
      state_nxt      = state;
      grant_nxt      = o_grant;
      last_grant_nxt = last_grant;
      o_m_arready    = '0;
      o_m_rvalid     = '0;
      o_s_arvalid    = 1'b0;
      o_s_rready     = 1'b0;
      case (state)
         IDLE: begin
            // Arbitration takes this cycle; the address goes out from ADDR.
            if (rr_found) begin
               grant_nxt = rr_pick;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            // A granted master that drops arvalid simply stalls here.
            o_s_arvalid          = i_m_arvalid[o_grant];
            o_m_arready[o_grant] = i_s_arready;
            if (i_m_arvalid[o_grant] && i_s_arready) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            o_m_rvalid[o_grant] = i_s_rvalid;
            o_s_rready          = i_m_rready[o_grant];
            if (i_s_rvalid && i_m_rready[o_grant] && i_s_rlast) begin
               last_grant_nxt = o_grant;
               state_nxt      = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Address and length come from the granted master; read data is shared.
   assign o_s_araddr = i_m_araddr[int'(o_grant)*ADDR_SIZE +: ADDR_SIZE];
   assign o_s_arlen  = i_m_arlen[int'(o_grant)*8 +: 8];
   assign o_m_rdata  = i_s_rdata;
   assign o_m_rresp  = i_s_rresp;
   assign o_m_rlast  = i_s_rlast;
   assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: per-master request queues drive the AR side,
// a randomized slave answers with bursts, and a monitor compares every AR and
// R handshake against a queue of expected transactions from a round-robin
// reference model.
module tb_axi_read_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int GW = 2;

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [7:0]  len;
   } req_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
   logic [N*AW-1:0] m_araddr;
   logic [N*8-1:0]  m_arlen;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic            m_rlast;
   logic            s_arvalid, s_arready;
   logic [AW-1:0]   s_araddr;
   logic [7:0]      s_arlen;
   logic            s_rvalid, s_rready;
   logic [DW-1:0]   s_rdata;
   logic [1:0]      s_rresp;
   logic            s_rlast;
   logic [GW-1:0]   grant;
   logic            busy;

   req_t  mq[N][$];
   req_t  mdl_q[N][$];
   req_t  exp_ar[$];
   beat_t slave_q[$];
   beat_t exp_r[$];

   int checks = 0;
   int errors = 0;
   int mdl_last = N - 1;
   int ar_pct = 100, rv_pct = 100, rr_pct = 100;
   int stall_beat = -1, stall_left = 0;
   int err_mode = 0;
   int cur_m = 0;
   int beats_done = 0;
   int drv_beats = 0;

   axi_read_arbiter #(
      .NUM_MASTERS(N),
      .ADDR_SIZE(AW),
      .DATA_SIZE(DW)
   ) dut (
      .i_aclk(clk),
      .i_areset_n(rst_n),
      .i_m_arvalid(m_arvalid),
      .o_m_arready(m_arready),
      .i_m_araddr(m_araddr),
      .i_m_arlen(m_arlen),
      .o_m_rvalid(m_rvalid),
      .i_m_rready(m_rready),
      .o_m_rdata(m_rdata),
      .o_m_rresp(m_rresp),
      .o_m_rlast(m_rlast),
      .o_s_arvalid(s_arvalid),
      .i_s_arready(s_arready),
      .o_s_araddr(s_araddr),
      .o_s_arlen(s_arlen),
      .i_s_rvalid(s_rvalid),
      .o_s_rready(s_rready),
      .i_s_rdata(s_rdata),
      .i_s_rresp(s_rresp),
      .i_s_rlast(s_rlast),
      .o_grant(grant),
      .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic bit drained();
      bit d;
      d = (exp_ar.size() == 0) && (exp_r.size() == 0) && (slave_q.size() == 0) && !busy;
      for (int m = 0; m < N; m++) if (mq[m].size() != 0) d = 1'b0;
      return d;
   endfunction

   task automatic load(input int m, input logic [31:0] addr, input logic [7:0] len);
      req_t r;
      r.m = m; r.addr = addr; r.len = len;
      mq[m].push_back(r);
      mdl_q[m].push_back(r);
   endtask

   // Reference: each time the channel frees, the next master after the
   // previous winner that still has pending work wins it.
   task automatic schedule();
      int pick;
      forever begin
         pick = -1;
         for (int k = 1; k <= N; k++) begin
            if (pick < 0 && mdl_q[(mdl_last + k) % N].size() > 0) pick = (mdl_last + k) % N;
         end
         if (pick < 0) break;
         exp_ar.push_back(mdl_q[pick].pop_front());
         mdl_last = pick;
      end
   endtask

   task automatic flush();
      for (int m = 0; m < N; m++) begin
         mq[m].delete();
         mdl_q[m].delete();
      end
      exp_ar.delete();
      slave_q.delete();
      exp_r.delete();
      mdl_last   = N - 1;
      stall_beat = -1;
      stall_left = 0;
      err_mode   = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flush();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int cyc;
      cyc = 0;
      @(negedge clk);
      while (cyc < 5000 && !drained()) begin
         @(negedge clk);
         cyc++;
      end
      chk(name, 64'(cyc < 5000), 64'd1);
      if (cyc >= 5000) do_reset();
   endtask

   // Master and slave drivers: handshakes sampled at negedge, inputs updated
   // just after the following posedge.
   initial begin
      bit    ar_hs, r_hs;
      logic  [N-1:0] mhs;
      logic  [7:0] alen;
      req_t  rtmp;
      beat_t bt;
      m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_rready = '0;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
      forever begin
         @(negedge clk);
         ar_hs = s_arvalid & s_arready;
         r_hs  = s_rvalid & s_rready;
         mhs   = m_arvalid & m_arready;
         alen  = s_arlen;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            m_arvalid = '0; m_rready = '0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
            drv_beats = 0;
            continue;
         end
         for (int m = 0; m < N; m++) begin
            if (mhs[m] && mq[m].size() > 0) rtmp = mq[m].pop_front();
            m_arvalid[m] = (mq[m].size() > 0);
            if (mq[m].size() > 0) begin
               m_araddr[m*AW +: AW] = mq[m][0].addr;
               m_arlen[m*8 +: 8]    = mq[m][0].len;
            end
         end
         if (ar_hs) begin
            drv_beats = 0;
            for (int b = 0; b <= int'(alen); b++) begin
               bt.data = $urandom;
               bt.resp = (err_mode != 0) ? 2'b10 : 2'($urandom_range(0, 3));
               bt.last = (b == int'(alen));
               slave_q.push_back(bt);
               exp_r.push_back(bt);
            end
         end
         if (r_hs && slave_q.size() > 0) begin
            bt = slave_q.pop_front();
            drv_beats++;
         end
         if (!(s_rvalid && !r_hs))
            s_rvalid = (slave_q.size() > 0) && (int'($urandom_range(0, 99)) < rv_pct);
         if (slave_q.size() > 0) begin
            s_rdata = slave_q[0].data;
            s_rresp = slave_q[0].resp;
            s_rlast = slave_q[0].last;
         end else begin
            s_rvalid = 1'b0;
            s_rlast  = 1'b0;
         end
         s_arready = (int'($urandom_range(0, 99)) < ar_pct);
         for (int m = 0; m < N; m++) m_rready[m] = (int'($urandom_range(0, 99)) < rr_pct);
         if (stall_beat >= 0 && drv_beats == stall_beat && stall_left > 0) begin
            m_rready = '0;
            stall_left--;
         end
      end
   end

   // Monitor: compares every handshake against the expected queues.
   initial begin
      req_t  e;
      beat_t b;
      logic  [N-1:0] mh;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (s_arvalid && s_arready) begin
               if (exp_ar.size() == 0) begin
                  chk("unexpected_ar", 64'd1, 64'd0);
               end else begin
                  e = exp_ar.pop_front();
                  chk("ar_grant", 64'(grant), 64'(e.m));
                  chk("ar_addr", 64'(s_araddr), 64'(e.addr));
                  chk("ar_len", 64'(s_arlen), 64'(e.len));
                  cur_m      = e.m;
                  beats_done = 0;
               end
            end
            if (m_rvalid != '0) begin
               chk("rvalid_route", 64'(m_rvalid), 64'(onehot(cur_m)));
               chk("rvalid_src", 64'(s_rvalid), 64'd1);
            end
            if (m_arready != '0)
               chk("arready_other", 64'(m_arready & ~onehot(int'(grant))), 64'd0);
            mh = m_rvalid & m_rready;
            if (s_rvalid && s_rready) begin
               chk("r_hs_route", 64'(mh), 64'(onehot(cur_m)));
               if (exp_r.size() == 0) begin
                  chk("unexpected_beat", 64'd1, 64'd0);
               end else begin
                  b = exp_r.pop_front();
                  chk("r_data", 64'(m_rdata), 64'(b.data));
                  chk("r_resp", 64'(m_rresp), 64'(b.resp));
                  chk("r_last", 64'(m_rlast), 64'(b.last));
               end
               beats_done++;
            end else if (mh != '0) begin
               chk("r_hs_without_slave", 64'(mh), 64'd0);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Directed scenarios followed by randomized rounds.
   initial begin
      int cyc;
      rst_n = 1'b0;
      flush();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
      chk("rst_s_rready", 64'(s_rready), 64'd0);
      chk("rst_m_arready", 64'(m_arready), 64'd0);
      chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Single request from master 1.
      @(posedge clk);
      #2;
      load(1, 32'h0000_1000, 8'd3);
      schedule();
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!m_arvalid[1] && cyc < 20);
      chk("t1_req_seen", 64'(m_arvalid[1]), 64'd1);
      chk("t1_idle_no_arvalid", 64'(s_arvalid), 64'd0);
      chk("t1_idle_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("t1_arvalid_1cyc", 64'(s_arvalid), 64'd1);
      chk("t1_grant", 64'(grant), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_arready_route", 64'(m_arready), 64'(4'b0010));
      wait_idle("t1_done");
      chk("t1_beats", 64'(beats_done), 64'd4);
      chk("t1_back_idle", 64'(busy), 64'd0);

      // Simultaneous requests from masters 0 and 1 right after reset.
      do_reset();
      @(posedge clk);
      #2;
      load(0, 32'h0000_0100, 8'd1);
      load(1, 32'h0000_1100, 8'd1);
      load(0, 32'h0000_0200, 8'd0);
      load(1, 32'h0000_1200, 8'd2);
      schedule();
      wait_idle("t2_done");

      // AR backpressure then an R stall on beat 2 of 4.
      @(posedge clk);
      #2;
      ar_pct = 0;
      stall_beat = 2;
      stall_left = 3;
      load(0, 32'h0000_2000, 8'd3);
      schedule();
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!s_arvalid && cyc < 20);
      for (int i = 0; i < 5; i++) begin
         chk("t3_ar_hold", 64'(s_arvalid), 64'd1);
         chk("t3_grant_hold", 64'(grant), 64'd0);
         @(negedge clk);
      end
      ar_pct = 100;
      wait_idle("t3_done");
      chk("t3_beats", 64'(beats_done), 64'd4);

      // Single-beat transfer with SLVERR, then a normal request.
      @(posedge clk);
      #2;
      err_mode = 1;
      load(2, 32'h0000_3000, 8'd0);
      schedule();
      wait_idle("t4_err_done");
      err_mode = 0;
      chk("t4_beats", 64'(beats_done), 64'd1);
      load(3, 32'h0000_4000, 8'd1);
      schedule();
      wait_idle("t4_next_done");

      // Reset in the middle of an 8-beat burst.
      @(posedge clk);
      #2;
      beats_done = 0;
      load(1, 32'h0000_5000, 8'd7);
      schedule();
      cyc = 0;
      while (beats_done < 2 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("t5_reached_beat2", 64'(beats_done >= 2), 64'd1);
      #1;
      rst_n = 1'b0;
      flush();
      #1;
      chk("t5_rst_grant", 64'(grant), 64'd0);
      chk("t5_rst_busy", 64'(busy), 64'd0);
      chk("t5_rst_m_rvalid", 64'(m_rvalid), 64'd0);
      chk("t5_rst_s_rready", 64'(s_rready), 64'd0);
      chk("t5_rst_s_arvalid", 64'(s_arvalid), 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2;
      load(1, 32'h0000_6100, 8'd0);
      load(0, 32'h0000_6000, 8'd1);
      load(3, 32'h0000_6300, 8'd2);
      schedule();
      wait_idle("t5_after_done");

      // Randomized rounds.
      for (int r = 0; r < 12; r++) begin
         @(posedge clk);
         #2;
         ar_pct = int'($urandom_range(20, 100));
         rv_pct = int'($urandom_range(30, 100));
         rr_pct = int'($urandom_range(30, 100));
         for (int m = 0; m < N; m++) begin
            int cnt;
            cnt = int'($urandom_range(0, 2));
            for (int k = 0; k < cnt; k++) load(m, $urandom, 8'($urandom_range(0, 7)));
         end
         schedule();
         wait_idle("rand_done");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one AXI read channel (AR + R) between NUM_MASTERS requesters, e.g. the per-core instruction caches and data caches, ahead of the memory interconnect.
- Arbitration is round-robin.
- One transaction is in flight at a time. A grant is held from the AR handshake until the R beat with RLAST is accepted.
- Write channels do not pass through this block.

Parameters:
- NUM_MASTERS, 2, number of requesting masters; must be >= 2.
- ADDR_SIZE, 32, address width.
- DATA_SIZE, 32, read data width.
- GW, $clog2(NUM_MASTERS), grant index width. Derived; not overridden.

Ports:
- i_aclk  in  1  system clock.
- i_areset_n  in  1  asynchronous active-low reset.
- i_m_arvalid  in  NUM_MASTERS  per-master AR valid.
- o_m_arready  out  NUM_MASTERS  per-master AR ready.
- i_m_araddr  in  NUM_MASTERS*ADDR_SIZE  per-master address; master k occupies bits [k*ADDR_SIZE +: ADDR_SIZE].
- i_m_arlen  in  NUM_MASTERS*8  per-master burst length minus 1.
- o_m_rvalid  out  NUM_MASTERS  per-master R valid.
- i_m_rready  in  NUM_MASTERS  per-master R ready.
- o_m_rdata  out  DATA_SIZE  read data, shared by all masters; qualified by o_m_rvalid.
- o_m_rresp  out  2  read response, shared by all masters.
- o_m_rlast  out  1  last beat, shared by all masters.
- o_s_arvalid  out  1  downstream AR valid.
- i_s_arready  in  1  downstream AR ready.
- o_s_araddr  out  ADDR_SIZE  downstream address.
- o_s_arlen  out  8  downstream burst length.
- i_s_rvalid  in  1  downstream R valid.
- o_s_rready  out  1  downstream R ready.
- i_s_rdata  in  DATA_SIZE  downstream read data.
- i_s_rresp  in  2  downstream read response.
- i_s_rlast  in  1  downstream last beat.
- o_grant  out  GW  index of the currently granted master.
- o_busy  out  1  high when state != IDLE.

Behaviour:
- Clock and reset: single clock i_aclk. Reset is asynchronous and active-low on i_areset_n.
- Reset values:
  - state = IDLE, o_grant = 0, last_grant = NUM_MASTERS-1, so master 0 has first priority.
  - All valid and ready outputs are 0. o_busy = 0.
- State machine, registered state:
  - IDLE:
    - If any i_m_arvalid bit is set, select the first requester scanning from (last_grant+1) mod NUM_MASTERS upward with wrap.
    - Register that index into o_grant and go to ADDR.
    - Arbitration costs 1 cycle; o_s_arvalid is never asserted in IDLE.
  - ADDR:
    - o_s_arvalid = i_m_arvalid[o_grant].
    - o_s_araddr and o_s_arlen are muxed from the granted master.
    - o_m_arready[o_grant] = i_s_arready. All other o_m_arready bits are 0.
    - On o_s_arvalid & i_s_arready, go to DATA.
  - DATA:
    - o_m_rvalid[o_grant] = i_s_rvalid. Other o_m_rvalid bits are 0.
    - o_s_rready = i_m_rready[o_grant].
    - rdata, rresp and rlast pass straight through, combinationally.
    - On i_s_rvalid & o_s_rready & i_s_rlast: last_grant <= o_grant, go to IDLE.
- Latency:
  - Request to downstream AR valid is exactly 1 cycle when the arbiter starts in IDLE.
  - The R path adds 0 cycles.
  - Back-to-back transactions have at least 1 idle cycle between the RLAST accept and the next o_s_arvalid.
- Ready rules outside the active phase:
  - o_s_rready = 0 outside DATA. Beats arriving while not in DATA are not accepted.
  - o_m_arready = 0 outside ADDR.
- Masters are required to hold arvalid and araddr stable until arready (AXI rule). If a granted master drops arvalid in ADDR, the arbiter stays in ADDR with o_s_arvalid low. It does not re-arbitrate.
- A single-beat transfer (arlen = 0) with RLAST on the first beat is legal and returns to IDLE.
- An R beat stalled by the master (rvalid & !rready, including the RLAST beat) holds the state. Nothing is dropped.
- Requests arriving during ADDR or DATA wait. They are considered at the next IDLE.
- An RRESP error is passed through unchanged and does not alter sequencing.
- Reset asserted mid-transaction returns to reset values immediately. The downstream slave is reset by the same signal.
- Only NUM_MASTERS values that are powers of 2 are required. For other values, round-robin selection must never produce an index >= NUM_MASTERS.

Test Plan:
- Single request: after reset, master 1 requests araddr = 0x0000_1000, arlen = 3.
  - o_grant = 1 next cycle, o_s_arvalid high.
  - 4 beats are routed only to o_m_rvalid[1].
  - Returns to IDLE after the RLAST accept.
- Simultaneous requests: masters 0 and 1 both request continuously.
  - Grants alternate 0,1,0,1 over 4 transactions.
  - The first grant after reset goes to master 0.
- Backpressure: i_s_arready held low 5 cycles, then master 0 drops rready on beat 2 of 4.
  - State holds, no beat is lost or duplicated, and data order matches the slave.
- Single-beat transfer (arlen = 0) with rresp = 2'b10 (SLVERR):
  - Error is delivered to the granted master.
  - Arbiter returns to IDLE.
  - Next request is granted normally.
- Reset mid-burst: i_areset_n pulsed low during beat 2 of 8.
  - All outputs return to 0, o_grant = 0, o_busy = 0.
  - Master 0 has priority on the next simultaneous request.
